// File: rtl/axi_node_pkg.sv
// Shared AXI node helpers: ID field split and FIFO count width.
package axi_node_pkg;
  localparam int MAX_TARG = 32;
  localparam int MAX_ID_W = 40;

  // Count needs one extra bit so that "full" (count == depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // One-hot port field sits in the low n_targ bits of an ID.
  function automatic logic [MAX_TARG-1:0] id_onehot(input logic [MAX_ID_W-1:0] id,
                                                    input int n_targ);
    logic [MAX_TARG-1:0] mask;
    mask = (MAX_TARG'(1) << n_targ) - MAX_TARG'(1);
    return id[MAX_TARG-1:0] & mask;
  endfunction

  // Binary port index sits above the one-hot field.
  function automatic logic [7:0] id_index(input logic [MAX_ID_W-1:0] id,
                                          input int n_targ, input int log_n);
    logic [MAX_ID_W-1:0] sh;
    sh = id >> n_targ;
    return sh[7:0] & ((8'(1) << log_n) - 8'(1));
  endfunction
endpackage

// File: rtl/generic_fifo_sync.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while
// empty are ignored.
module generic_fifo_sync
  import axi_node_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end
endmodule

// File: rtl/axi_w_id_fifo.sv
// W-channel steering: queues granted AW IDs and routes the W burst of the
// head ID's port to the master side. Define AXI_W_ID_FIFO_FALLTHROUGH_EN to
// let an ID pushed into an empty FIFO steer W in the same cycle.
module axi_w_id_fifo
  import axi_node_pkg::*;
#(
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
  parameter int FIFO_DEPTH  = 8,
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_USER_W  = 6
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       push_ID_i,
  input  logic [LOG_N_TARG+N_TARG_PORT-1:0]          ID_i,
  output logic                                       grant_FIFO_ID_o,
  input  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]     wdata_i,
  input  logic [N_TARG_PORT-1:0][AXI_DATA_W/8-1:0]   wstrb_i,
  input  logic [N_TARG_PORT-1:0]                     wlast_i,
  input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]     wuser_i,
  input  logic [N_TARG_PORT-1:0]                     wvalid_i,
  output logic [N_TARG_PORT-1:0]                     wready_o,
  output logic [AXI_DATA_W-1:0]                      wdata_o,
  output logic [AXI_DATA_W/8-1:0]                    wstrb_o,
  output logic                                       wlast_o,
  output logic [AXI_USER_W-1:0]                      wuser_o,
  output logic                                       wvalid_o,
  input  logic                                       wready_i
);
  localparam int ID_W  = LOG_N_TARG + N_TARG_PORT;
  localparam int CNT_W = cnt_w(FIFO_DEPTH);

  logic [ID_W-1:0]        head_id, sel_id;
  logic [CNT_W-1:0]       fifo_cnt;
  logic [N_TARG_PORT-1:0] sel_oh;
  logic                   full, empty, fifo_push, fifo_pop, hs_last, sel_act;

`ifdef AXI_W_ID_FIFO_FALLTHROUGH_EN
  // An empty FIFO lets the incoming ID steer directly; if its single-beat
  // burst completes right away the ID is consumed without being stored.
  assign sel_act   = !rst && (!empty || push_ID_i);
  assign sel_id    = empty ? ID_i : head_id;
  assign fifo_push = push_ID_i && !full && !(empty && hs_last);
`else
  assign sel_act   = !rst && !empty;
  assign sel_id    = head_id;
  assign fifo_push = push_ID_i && !full;
`endif

  assign fifo_pop        = hs_last && !empty;
  assign sel_oh          = sel_act ? N_TARG_PORT'(id_onehot(MAX_ID_W'(sel_id), N_TARG_PORT)) : '0;
  assign wvalid_o        = |(wvalid_i & sel_oh);
  assign wready_o        = sel_oh & {N_TARG_PORT{wready_i}};
  assign hs_last         = wvalid_o && wready_i && wlast_o;
  assign grant_FIFO_ID_o = rst || (fifo_cnt != CNT_W'(FIFO_DEPTH));

  generic_fifo_sync #(.DATA_W(ID_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .data_in  (ID_i),
    .pop      (fifo_pop),
    .data_out (head_id),
    .full     (full),
    .empty    (empty),
    .count    (fifo_cnt)
  );

  // AND-OR mux of the selected lane; all zero when nothing is selected.
  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    wuser_o = '0;
    wlast_o = 1'b0;
    for (int p = 0; p < N_TARG_PORT; p++) begin
      if (sel_oh[p]) begin
        wdata_o = wdata_o | wdata_i[p];
        wstrb_o = wstrb_o | wstrb_i[p];
        wuser_o = wuser_o | wuser_i[p];
        wlast_o = wlast_o | wlast_i[p];
      end
    end
  end
endmodule
